// File: rtl/ascon_job_sequencer_if.sv
// Job descriptor handshake between the register slave and the sequencer.
// The host side drives the descriptor and the sequencer returns ready.
interface ascon_job_sequencer_if #(
    parameter int LEN_W = 7
);
    logic             job_valid;
    logic             job_ready;
    logic [1:0]       job_mode;
    logic [LEN_W-1:0] job_ad_len;
    logic [LEN_W-1:0] job_msg_len;

    modport master (
        output job_valid, job_mode, job_ad_len, job_msg_len,
        input  job_ready
    );

    modport slave (
        input  job_valid, job_mode, job_ad_len, job_msg_len,
        output job_ready
    );
endinterface

// File: rtl/ascon_job_sequencer.sv
// Walks one AEAD job through the ASCON core: start, AD blocks,
// message blocks and tag, with protocol-error, timeout and abort exits.
module ascon_job_sequencer #(
    parameter int LEN_W   = 7,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   nRST,
    ascon_job_sequencer_if.slave   job,
    input  logic                   abort,
    output logic                   core_start,
    output logic [1:0]             core_mode,
    input  logic                   core_ad_read,
    input  logic                   core_ctv,
    input  logic                   core_tv,
    output logic                   src_sel,
    output logic [LEN_W-4:0]       blk_idx,
    output logic [3:0]             blk_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int IW = LEN_W - 3;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_AD, S_MSG, S_TAG, S_DONE
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] ad_len;
    logic [LEN_W-1:0] msg_len;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    tcnt;
    logic             err_q;
    logic [LEN_W-1:0] cur_len;
    logic             last;
    logic             tmo;

    // Length of the phase currently being presented and its block math.
    always_comb begin
        cur_len = (state == S_AD) ? ad_len : msg_len;
        last    = (idx == cur_len[LEN_W-1:3]);
        tmo     = (tcnt == CW'(TIMEOUT - 1));
    end

    // Job FSM: one register set, outputs decoded from it below.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state     <= S_IDLE;
            ad_len    <= '0;
            msg_len   <= '0;
            core_mode <= '0;
            idx       <= '0;
            tcnt      <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    idx  <= '0;
                    tcnt <= '0;
                    if (job.job_valid) begin
                        core_mode <= job.job_mode;
                        ad_len    <= job.job_ad_len;
                        msg_len   <= job.job_msg_len;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    idx  <= '0;
                    tcnt <= '0;
                    if (abort)
                        state <= S_IDLE;
                    else if (ad_len != '0)
                        state <= S_AD;
                    else
                        state <= S_MSG;
                end
                S_AD: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (core_ctv || core_tv) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else if (core_ad_read) begin
                        tcnt <= '0;
                        if (last) begin
                            state <= S_MSG;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else if (tmo) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                S_MSG: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (core_ad_read || core_tv) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else if (core_ctv) begin
                        tcnt <= '0;
                        if (last)
                            state <= S_TAG;
                        else
                            idx <= idx + IW'(1);
                    end else if (tmo) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                S_TAG: begin
                    if (abort) begin
                        state <= S_IDLE;
                        idx   <= '0;
                    end else if (core_ad_read || core_ctv) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else if (core_tv) begin
                        state <= S_DONE;
                        tcnt  <= '0;
                    end else if (tmo) begin
                        state <= S_IDLE;
                        idx   <= '0;
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    tcnt  <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    idx   <= '0;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    // Outputs depend only on registered state, never on core strobes.
    always_comb begin
        job.job_ready = (state == S_IDLE);
        busy          = (state != S_IDLE);
        core_start    = (state == S_START);
        src_sel       = (state == S_AD);
        done          = (state == S_DONE);
        err           = err_q;
        blk_idx       = idx;
        blk_len       = 4'd0;
        if (state == S_AD || state == S_MSG) begin
            if (idx < cur_len[LEN_W-1:3])
                blk_len = 4'd8;
            else
                blk_len = {1'b0, cur_len[2:0]};
        end
    end
endmodule

// File: tb/tb_ascon_job_sequencer.sv
// Directed and randomized jobs checked against a block-list model
// built from the length arithmetic of the job descriptor.
module tb_ascon_job_sequencer;
    localparam int LEN_W = 7;

    logic       clk;
    logic       nRST;
    logic       abort;
    logic       core_start;
    logic [1:0] core_mode;
    logic       core_ad_read;
    logic       core_ctv;
    logic       core_tv;
    logic       src_sel;
    logic [3:0] blk_idx;
    logic [3:0] blk_len;
    logic       busy;
    logic       done;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit src;
        int idx;
        int len;
    } blk_t;

    ascon_job_sequencer_if #(.LEN_W(LEN_W)) jif ();

    ascon_job_sequencer #(.LEN_W(LEN_W), .TIMEOUT(255)) dut (
        .clk          (clk),
        .nRST         (nRST),
        .job          (jif),
        .abort        (abort),
        .core_start   (core_start),
        .core_mode    (core_mode),
        .core_ad_read (core_ad_read),
        .core_ctv     (core_ctv),
        .core_tv      (core_tv),
        .src_sel      (src_sel),
        .blk_idx      (blk_idx),
        .blk_len      (blk_len),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, 32'(jif.job_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_src"}, 32'(src_sel), 0);
        chk({tag, "_idx"}, 32'(blk_idx), 0);
        chk({tag, "_len"}, 32'(blk_len), 0);
    endtask

    task automatic accept(input int ad, input int msg, input logic [1:0] m);
        chk("acc_ready", 32'(jif.job_ready), 1);
        jif.job_valid   = 1'b1;
        jif.job_mode    = m;
        jif.job_ad_len  = LEN_W'(ad);
        jif.job_msg_len = LEN_W'(msg);
        step();
        jif.job_valid = 1'b0;
        chk("start_pulse", 32'(core_start), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_mode", 32'(core_mode), 32'(m));
        step();
        chk("start_once", 32'(core_start), 0);
    endtask

    task automatic run_job(input int ad, input int msg, input logic [1:0] m);
        blk_t q[$];
        blk_t b;
        int nad;
        nad = (ad == 0) ? 0 : ad / 8 + 1;
        for (int i = 0; i < nad; i++) begin
            b.src = 1; b.idx = i; b.len = (i < ad / 8) ? 8 : ad % 8;
            q.push_back(b);
        end
        for (int i = 0; i < msg / 8 + 1; i++) begin
            b.src = 0; b.idx = i; b.len = (i < msg / 8) ? 8 : msg % 8;
            q.push_back(b);
        end
        accept(ad, msg, m);
        foreach (q[k]) begin
            int w;
            w = $urandom_range(0, 3);
            for (int c = 0; c <= w; c++) begin
                chk("blk_src", 32'(src_sel), 32'(q[k].src));
                chk("blk_idx", 32'(blk_idx), 32'(q[k].idx));
                chk("blk_len", 32'(blk_len), 32'(q[k].len));
                chk("blk_done", 32'(done), 0);
                chk("blk_err", 32'(err), 0);
                if (c == w) begin
                    if (q[k].src) core_ad_read = 1'b1;
                    else core_ctv = 1'b1;
                end
                step();
                core_ad_read = 1'b0;
                core_ctv     = 1'b0;
            end
        end
        for (int c = 0; c < int'($urandom_range(1, 4)); c++) begin
            chk("tag_busy", 32'(busy), 1);
            chk("tag_src", 32'(src_sel), 0);
            chk("tag_done", 32'(done), 0);
            step();
        end
        core_tv = 1'b1;
        step();
        core_tv = 1'b0;
        chk("done_pulse", 32'(done), 1);
        chk("done_err", 32'(err), 0);
        chk("done_ready", 32'(jif.job_ready), 0);
        step();
        chk("after_done", 32'(done), 0);
        chk_idle("post_job");
    endtask

    initial begin
        int bad;
        nRST            = 1'b0;
        abort           = 1'b0;
        core_ad_read    = 1'b0;
        core_ctv        = 1'b0;
        core_tv         = 1'b0;
        jif.job_valid   = 1'b0;
        jif.job_mode    = 2'd0;
        jif.job_ad_len  = '0;
        jif.job_msg_len = '0;
        #12;
        chk_idle("rst");
        chk("rst_start", 32'(core_start), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mode", 32'(core_mode), 0);
        nRST = 1'b1;
        step();

        core_tv = 1'b1;
        core_ctv = 1'b1;
        step();
        core_tv = 1'b0;
        core_ctv = 1'b0;
        chk("idle_strobe_err", 32'(err), 0);
        chk_idle("idle_strobe");

        run_job(20, 16, 2'd1);
        run_job(0, 0, 2'd2);
        run_job(8, 5, 2'd3);
        for (int r = 0; r < 4; r++)
            run_job(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
                    2'($urandom_range(0, 3)));
        run_job(127, 127, 2'd0);

        accept(10, 3, 2'd1);
        chk("ad_phase", 32'(src_sel), 1);
        core_ctv = 1'b1;
        step();
        core_ctv = 1'b0;
        chk("ctv_in_ad_err", 32'(err), 1);
        chk("ctv_in_ad_done", 32'(done), 0);
        chk_idle("ctv_in_ad");
        step();
        chk("err_once", 32'(err), 0);

        accept(0, 9, 2'd0);
        core_ctv = 1'b1;
        core_ad_read = 1'b1;
        step();
        core_ctv = 1'b0;
        core_ad_read = 1'b0;
        chk("mixed_err", 32'(err), 1);
        chk_idle("mixed");
        step();

        accept(0, 0, 2'd2);
        core_ctv = 1'b1;
        step();
        core_ctv = 1'b0;
        bad = 0;
        for (int k = 0; k < 255; k++) begin
            if (err !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        chk("tmo_early", 32'(bad), 0);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_done", 32'(done), 0);
        chk_idle("tmo");
        step();

        accept(20, 4, 2'd1);
        abort = 1'b1;
        core_ad_read = 1'b1;
        step();
        abort = 1'b0;
        core_ad_read = 1'b0;
        chk("abort_err", 32'(err), 0);
        chk_idle("abort");
        step();
        chk("abort_err2", 32'(err), 0);
        chk("abort_done2", 32'(done), 0);

        accept(0, 30, 2'd3);
        core_ctv = 1'b1;
        step();
        core_ctv = 1'b0;
        chk("mid_msg_idx", 32'(blk_idx), 1);
        #2;
        nRST = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst_mode", 32'(core_mode), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_start", 32'(core_start), 0);
        #3;
        nRST = 1'b1;
        step();
        chk("arst_after_err", 32'(err), 0);
        run_job(13, 22, 2'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ascon_job_sequencer.md
# ascon_job_sequencer

Sequences one complete AEAD job through the ASCON core. It accepts a job descriptor (mode, associated-data byte length, message byte length) and pulses the core start. It then steers the core's block input between the AD source and the message buffer, presenting the block index and valid-byte count for each block. It tracks the core's consumption strobes through the AD, message and tag phases, and reports done or error. It sits between the Wishbone register slave and the core/memory/AD-loader datapath, replacing ad-hoc start/AD-select control.

## Interface
- LEN_W, 7, byte-length width; max job length per field 2^LEN_W-1 bytes
- TIMEOUT, 255, max cycles waited for any core strobe before error
- clk  in  1  clock; all state changes on rising edge
- nRST  in  1  reset; asynchronous, active-low
- job_valid  in  1  descriptor valid
- job_ready  out  1  high in IDLE; job accepted when job_valid && job_ready
- job_mode  in  2  core mode, latched on accept
- job_ad_len  in  LEN_W  AD length in bytes, latched on accept
- job_msg_len  in  LEN_W  message length in bytes, latched on accept
- abort  in  1  synchronous abort request
- core_start  out  1  one-cycle start pulse to core
- core_mode  out  2  latched mode, stable for whole job
- core_ad_read  in  1  core consumed current AD block
- core_ctv  in  1  core consumed current message block / output block valid
- core_tv  in  1  tag valid
- src_sel  out  1  1 = AD source, 0 = message buffer
- blk_idx  out  LEN_W-3  index of block currently presented
- blk_len  out  4  valid bytes in presented block, 0..8
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, job completed
- err  out  1  one-cycle pulse, job terminated by protocol error or timeout

## Operation
- States: IDLE, START, AD, MSG, TAG, DONE.
- IDLE: job_ready=1. On accept: latch mode and both lengths, then go to START.
- START: core_start=1 for exactly this cycle. Next state is AD if ad_len≠0, else MSG. blk_idx=0.
- Block counts:
  - AD blocks = ad_len==0 ? 0 : ad_len/8+1.
  - Message blocks = msg_len/8+1, so there is always at least one message block.
  - A length that is a multiple of 8 yields a final 0-byte padding block.
- blk_len = 8 for idx < len/8, else len%8. Length is ad_len in AD and msg_len in MSG.
- AD: src_sel=1. core_ad_read consumes the current block.
  - If not the last block: idx+1.
  - If the last block: go to MSG with idx=0.
- MSG: src_sel=0. core_ctv consumes the current block.
  - If not the last block: idx+1.
  - If the last block: go to TAG.
- TAG: core_tv moves to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Protocol errors raise err for one cycle, go to IDLE, and do not assert done:
  - core_ctv or core_tv in AD
  - core_ad_read or core_tv in MSG
  - core_ad_read or core_ctv in TAG
  - any strobe in IDLE is ignored (no err)
- Timeout: a counter resets on state entry and on every consumed strobe. If it reaches TIMEOUT in AD, MSG or TAG, raise err and go to IDLE.
- abort in any non-IDLE state: go to IDLE next cycle with no done and no err. abort has priority over strobes and timeout. abort in IDLE has no effect.
- Simultaneous legal strobe plus error strobe in the same cycle counts as an error.
- src_sel is 0 outside AD. blk_idx and blk_len are 0 in IDLE.

## Timing
- Reset values: state IDLE, job_ready=1, busy=0, core_start=0, done=0, err=0, src_sel=0, blk_idx=0, blk_len=0, core_mode=0, timeout counter=0.
- Reset mid-job returns to IDLE immediately (asynchronous); no done or err is emitted.
- Accept in cycle T → core_start high in T+1 → AD/MSG presented from T+2.
- A strobe sampled in cycle N takes effect in N+1: next blk_idx/blk_len, or the state change.
- core_tv in cycle N → done=1 in N+1 → job_ready=1 in N+2. Back-to-back jobs are therefore accepted at N+2 at the earliest.
- All outputs are registered or decoded from registered state only. No combinational path exists from core strobes to outputs.

## Test plan
- ad_len=20, msg_len=16: AD blk_len 8,8,4; MSG blk_len 8,8,0. One core_start; done one cycle after core_tv; exactly 3 ad_read and 3 ctv consumed.
- ad_len=0, msg_len=0: START goes directly to MSG. One block with blk_len=0. Then core_tv → done; src_sel never 1.
- ad_len=8, msg_len=5: AD blocks 8,0; MSG block 5. Check blk_idx sequence 0,1 then 0.
- core_ctv asserted during AD phase → err pulse next cycle, state IDLE, no done.
- No strobe for 255 cycles in TAG → err at timeout. Separately, abort at the same cycle as core_ad_read → IDLE, neither err nor done.
- nRST asserted mid-MSG: all outputs return to reset values asynchronously. A new job then completes normally.
